// File: rtl/data_check.sv
// ============================================================================
// data_check : AXI-Stream sink that checks a lane-replicated 16-bit counting
//              pattern, counts beats/errors and latches the first failure.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module data_check #(
  parameter int DW = 512
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [31:0]   expected_cycles,
  input  logic [3:0]    throttle,
  input  logic [DW-1:0] axis_tdata,
  input  logic          axis_tvalid,
  output logic          axis_tready,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [31:0]   beat_count,
  output logic [31:0]   error_count,
  output logic [31:0]   first_err_beat,
  output logic [15:0]   first_err_data,
  output logic          overrun
);

  localparam int LANES = DW / 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] exp_q, exp_d;
  logic [3:0]  stall_q, stall_d;
  logic [3:0]  thr_q, thr_d;
  logic [31:0] cycles_q, cycles_d;
  logic [31:0] beat_q, beat_d;
  logic [31:0] err_q, err_d;
  logic [31:0] ferr_beat_q, ferr_beat_d;
  logic [15:0] ferr_data_q, ferr_data_d;
  logic        overrun_q, overrun_d;

  logic             xfer;
  logic [15:0]      l0;
  logic [LANES-1:0] lane_mis;
  logic             bad;
  logic [31:0]      beat_inc;

  assign l0 = axis_tdata[15:0];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lane_mis[g] = (axis_tdata[g*16 +: 16] != l0);
  end

  assign bad      = (|lane_mis) | (l0 != exp_q);
  assign beat_inc = beat_q + 32'd1;

  // Ready depends only on registered state, never on tvalid.
  assign axis_tready = ((state_q == S_CHECK) && (stall_q == 4'd0)) || (state_q == S_DONE);
  assign xfer        = axis_tvalid & axis_tready;

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    stall_d     = stall_q;
    thr_d       = thr_q;
    cycles_d    = cycles_q;
    beat_d      = beat_q;
    err_d       = err_q;
    ferr_beat_d = ferr_beat_q;
    ferr_data_d = ferr_data_q;
    overrun_d   = overrun_q;

    if (start) begin
      // Any beat that happens to transfer alongside start is dropped.
      state_d     = (expected_cycles == 32'd0) ? S_DONE : S_CHECK;
      exp_d       = 16'd0;
      stall_d     = 4'd0;
      thr_d       = throttle;
      cycles_d    = expected_cycles;
      beat_d      = 32'd0;
      err_d       = 32'd0;
      ferr_beat_d = 32'd0;
      ferr_data_d = 16'd0;
      overrun_d   = 1'b0;
    end else begin
      case (state_q)
        S_CHECK: begin
          if (stall_q != 4'd0) begin
            stall_d = stall_q - 4'd1;
          end
          if (xfer) begin
            beat_d  = beat_inc;
            stall_d = thr_q;
            exp_d   = l0 + 16'd1;
            if (bad) begin
              if (err_q != 32'hFFFF_FFFF) begin
                err_d = err_q + 32'd1;
              end
              if (err_q == 32'd0) begin
                ferr_beat_d = beat_q;
                ferr_data_d = l0;
              end
            end
            if (beat_inc == cycles_q) begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (xfer) begin
            overrun_d = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      exp_q       <= 16'd0;
      stall_q     <= 4'd0;
      thr_q       <= 4'd0;
      cycles_q    <= 32'd0;
      beat_q      <= 32'd0;
      err_q       <= 32'd0;
      ferr_beat_q <= 32'd0;
      ferr_data_q <= 16'd0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      stall_q     <= stall_d;
      thr_q       <= thr_d;
      cycles_q    <= cycles_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
      ferr_beat_q <= ferr_beat_d;
      ferr_data_q <= ferr_data_d;
      overrun_q   <= overrun_d;
    end
  end

  assign busy           = (state_q == S_CHECK);
  assign done           = (state_q == S_DONE);
  assign pass           = done & (err_q == 32'd0) & ~overrun_q;
  assign beat_count     = beat_q;
  assign error_count    = err_q;
  assign first_err_beat = ferr_beat_q;
  assign first_err_data = ferr_data_q;
  assign overrun        = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_data_check.sv
// ============================================================================
// tb_data_check : directed self-checking bench for data_check.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_data_check;

  localparam int DW    = 128;
  localparam int BOUND = 64;

  logic          clk;
  logic          resetn;
  logic          start;
  logic [31:0]   expected_cycles;
  logic [3:0]    throttle;
  logic [DW-1:0] axis_tdata;
  logic          axis_tvalid;
  logic          axis_tready;
  logic          busy;
  logic          done;
  logic          pass;
  logic [31:0]   beat_count;
  logic [31:0]   error_count;
  logic [31:0]   first_err_beat;
  logic [15:0]   first_err_data;
  logic          overrun;

  int vectors     = 0;
  int miscompares = 0;

  data_check #(.DW(DW)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .start          (start),
    .expected_cycles(expected_cycles),
    .throttle       (throttle),
    .axis_tdata     (axis_tdata),
    .axis_tvalid    (axis_tvalid),
    .axis_tready    (axis_tready),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .beat_count     (beat_count),
    .error_count    (error_count),
    .first_err_beat (first_err_beat),
    .first_err_data (first_err_data),
    .overrun        (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] lanes(input logic [15:0] v);
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 16; i++) r[i*16 +: 16] = v;
    return r;
  endfunction

  task automatic pulse_start(input logic [31:0] n, input logic [3:0] thr);
    start           = 1'b1;
    expected_cycles = n;
    throttle        = thr;
    tick();
    start = 1'b0;
  endtask

  // Offer one beat, wait (bounded) for ready, return cycles spent.
  task automatic send(input logic [DW-1:0] d, output int cyc);
    cyc         = 0;
    axis_tdata  = d;
    axis_tvalid = 1'b1;
    while (!axis_tready && cyc < BOUND) begin
      tick();
      cyc++;
    end
    chk("ready_wait", {31'd0, axis_tready}, 32'd1);
    if (axis_tready) begin
      tick();
      cyc++;
    end
  endtask

  task automatic send_val(input logic [15:0] v, output int cyc);
    send(lanes(v), cyc);
  endtask

  initial begin
    int            c;
    int            total;
    logic [DW-1:0] d;

    resetn          = 1'b0;
    start           = 1'b0;
    expected_cycles = 32'd0;
    throttle        = 4'd0;
    axis_tdata      = '0;
    axis_tvalid     = 1'b0;
    tick();
    tick();
    chk("rst_tready", {31'd0, axis_tready}, 32'd0);
    chk("rst_busy",   {31'd0, busy},        32'd0);
    chk("rst_done",   {31'd0, done},        32'd0);
    chk("rst_pass",   {31'd0, pass},        32'd0);
    chk("rst_beats",  beat_count,           32'd0);
    chk("rst_errs",   error_count,          32'd0);
    resetn = 1'b1;
    tick();
    chk("idle_tready", {31'd0, axis_tready}, 32'd0);

    // Clean run 0..9, no throttle: one beat per cycle.
    pulse_start(32'd10, 4'd0);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    total = 0;
    for (int i = 0; i < 10; i++) begin
      send_val(16'(i), c);
      total += c;
    end
    axis_tvalid = 1'b0;
    chk("t1_cycles", 32'(total), 32'd10);
    chk("t1_done",   {31'd0, done}, 32'd1);
    chk("t1_pass",   {31'd0, pass}, 32'd1);
    chk("t1_beats",  beat_count,    32'd10);
    chk("t1_errs",   error_count,   32'd0);
    tick();
    chk("t1_hold",   beat_count,    32'd10);

    // Dropped value 3.
    pulse_start(32'd5, 4'd0);
    send_val(16'd0, c); send_val(16'd1, c); send_val(16'd2, c);
    send_val(16'd4, c); send_val(16'd5, c);
    axis_tvalid = 1'b0;
    chk("t2_errs",  error_count,             32'd1);
    chk("t2_fbeat", first_err_beat,          32'd3);
    chk("t2_fdata", {16'd0, first_err_data}, 32'h0004);
    chk("t2_pass",  {31'd0, pass},           32'd0);
    chk("t2_done",  {31'd0, done},           32'd1);

    // Lane 7 corrupted on beat 2.
    pulse_start(32'd4, 4'd0);
    send_val(16'd0, c); send_val(16'd1, c);
    d = lanes(16'd2);
    d[7*16 +: 16] = 16'hDEAD;
    send(d, c);
    send_val(16'd3, c);
    axis_tvalid = 1'b0;
    chk("t3_errs",  error_count,             32'd1);
    chk("t3_fbeat", first_err_beat,          32'd2);
    chk("t3_fdata", {16'd0, first_err_data}, 32'd2);
    chk("t3_beats", beat_count,              32'd4);

    // Throttle 2 with tvalid held: 1,0,0 pattern, 6 beats in 16 cycles.
    pulse_start(32'd6, 4'd2);
    total = 0;
    send_val(16'd0, c);
    total += c;
    chk("t4_stall", {31'd0, axis_tready}, 32'd0);
    for (int i = 1; i < 6; i++) begin
      send_val(16'(i), c);
      total += c;
    end
    axis_tvalid = 1'b0;
    chk("t4_cycles", 32'(total),   32'd16);
    chk("t4_pass",   {31'd0, pass}, 32'd1);

    // Resync at FFFE costs one error, then the 16-bit wrap is clean.
    pulse_start(32'd4, 4'd0);
    send_val(16'hFFFE, c); send_val(16'hFFFF, c);
    send_val(16'h0000, c); send_val(16'h0001, c);
    axis_tvalid = 1'b0;
    chk("t5_errs",  error_count,             32'd1);
    chk("t5_fbeat", first_err_beat,          32'd0);
    chk("t5_fdata", {16'd0, first_err_data}, 32'h0000FFFE);
    chk("t5_beats", beat_count,              32'd4);

    // 12 beats offered against 10 expected: overrun.
    pulse_start(32'd10, 4'd0);
    for (int i = 0; i < 12; i++) send_val(16'(i), c);
    axis_tvalid = 1'b0;
    chk("t6_done",    {31'd0, done},    32'd1);
    chk("t6_overrun", {31'd0, overrun}, 32'd1);
    chk("t6_pass",    {31'd0, pass},    32'd0);
    chk("t6_beats",   beat_count,       32'd10);
    chk("t6_errs",    error_count,      32'd0);

    // Zero-length run goes straight to DONE with pass.
    pulse_start(32'd0, 4'd0);
    chk("z_done",    {31'd0, done},    32'd1);
    chk("z_pass",    {31'd0, pass},    32'd1);
    chk("z_overrun", {31'd0, overrun}, 32'd0);

    // Restart mid-run; the beat coincident with start is discarded.
    pulse_start(32'd10, 4'd0);
    send_val(16'd0, c); send_val(16'd1, c); send_val(16'd2, c);
    axis_tdata  = lanes(16'd3);
    axis_tvalid = 1'b1;
    pulse_start(32'd3, 4'd0);
    axis_tvalid = 1'b0;
    chk("rs_busy",  {31'd0, busy}, 32'd1);
    chk("rs_beats", beat_count,    32'd0);
    send_val(16'd0, c); send_val(16'd1, c); send_val(16'd2, c);
    axis_tvalid = 1'b0;
    chk("rs_pass",  {31'd0, pass}, 32'd1);
    chk("rs_beats3", beat_count,   32'd3);

    // Asynchronous reset mid-run.
    pulse_start(32'd10, 4'd0);
    send_val(16'd0, c); send_val(16'd1, c);
    axis_tvalid = 1'b0;
    resetn = 1'b0;
    #1;
    chk("ar_tready", {31'd0, axis_tready}, 32'd0);
    chk("ar_busy",   {31'd0, busy},        32'd0);
    chk("ar_beats",  beat_count,           32'd0);
    #2;
    resetn = 1'b1;
    tick();
    chk("ar_idle",   {31'd0, busy | done}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
